systolic_feeder: RTL and testbench

- Input-side sequencer for the weight-stationary MAC array: it drives the PE ports (control, wt_path_in, data_in) that each MAC consumes.
- Phase 1: loads one weight per PE by shifting weight rows down the columns with control asserted.
- Phase 2: streams activation vectors into the array rows with per-row diagonal skew, plus a skewed valid side-band for the downstream output collector.
- Sits between the activation/weight buffers and the array's top and left edges.

---
 rtl/feeder_pkg.sv | 18 +
 rtl/skew_line.sv | 41 ++++
 rtl/systolic_feeder.sv | 141 ++++++++++++++
 tb/tb_systolic_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and default geometry for the MAC array input feeder.
// Also used by the array and the output collector.
package feeder_pkg;

  localparam int unsigned ROWS_DEF      = 4;
  localparam int unsigned COLS_DEF      = 4;
  localparam int unsigned BIT_WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WT,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth registered delay line carrying one element plus its valid bit.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_data, in_valid   element written every cycle
//   out_data, out_valid element delayed by DEPTH cycles
module skew_line
  import feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = BIT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  logic [W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Shift chain: stage 0 takes the input, each later stage copies its predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Input-side sequencer for the weight-stationary MAC array.
// Loads ROWS weight rows down the columns (ctrl_out high one cycle per beat),
// then streams activation vectors into the rows with a per-row diagonal skew.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start, num_vec           job start pulse (IDLE only) and vector count
//   wt_valid/ready/data      weight-row beats, bottom row first
//   act_valid/ready/data     activation vectors
//   ctrl_out, wt_path_out    PE control broadcast and top-row weight path
//   data_out, row_valid_out  skewed left-column data and valid side-band
//   busy, done               job status
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned ROWS      = ROWS_DEF,
  parameter int unsigned COLS      = COLS_DEF,
  parameter int unsigned bit_width = BIT_WIDTH_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_vec,
  input  logic                      wt_valid,
  output logic                      wt_ready,
  input  logic [COLS*bit_width-1:0] wt_data,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [ROWS*bit_width-1:0] act_data,
  output logic                      ctrl_out,
  output logic [COLS*bit_width-1:0] wt_path_out,
  output logic [ROWS*bit_width-1:0] data_out,
  output logic [ROWS-1:0]           row_valid_out,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned BCW        = $clog2(ROWS + 1);
  localparam int unsigned FLUSH_LAST = (ROWS > 1) ? ROWS - 2 : 0;

  feeder_state_t             state_q, state_d;
  logic [CNT_W-1:0]          vec_left_q, vec_left_d;
  logic [BCW-1:0]            beat_cnt_q, beat_cnt_d;
  logic [BCW-1:0]            flush_cnt_q, flush_cnt_d;
  logic                      ctrl_d;
  logic [COLS*bit_width-1:0] wt_path_d;
  logic                      wt_hs;
  logic                      act_hs;

  // Ready is decoded from state so it drops on the edge that takes the last beat/vector.
  assign wt_ready  = (state_q == LOAD_WT);
  assign act_ready = (state_q == STREAM) && (vec_left_q != '0);
  assign wt_hs     = wt_valid && wt_ready;
  assign act_hs    = act_valid && act_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    vec_left_d  = vec_left_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ctrl_d      = 1'b0;
    wt_path_d   = wt_path_out;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_left_d = num_vec;
          beat_cnt_d = '0;
          state_d    = LOAD_WT;
        end
      end
      LOAD_WT: begin
        // ctrl_out pulses only with a fresh beat so PEs never shift stale weights.
        if (wt_hs) begin
          ctrl_d     = 1'b1;
          wt_path_d  = wt_data;
          beat_cnt_d = beat_cnt_q + BCW'(1);
          if (beat_cnt_q == BCW'(ROWS - 1)) begin
            flush_cnt_d = '0;
            state_d     = (vec_left_q == '0) ? FLUSH : STREAM;
          end
        end
      end
      STREAM: begin
        if (act_hs) begin
          vec_left_d = vec_left_q - CNT_W'(1);
          if (vec_left_q == CNT_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        // ROWS-1 bubble cycles let the deepest skew line drain.
        if (flush_cnt_q == BCW'(FLUSH_LAST)) state_d = DONE;
        else                                 flush_cnt_d = flush_cnt_q + BCW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_left_q  <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      ctrl_out    <= 1'b0;
      wt_path_out <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_left_q  <= vec_left_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ctrl_out    <= ctrl_d;
      wt_path_out <= wt_path_d;
      busy        <= (state_d != IDLE);
      done        <= (state_d == DONE);
    end
  end

  // Row r is delayed r+1 cycles; bubbles inject a zero element with valid low.
  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    skew_line #(
      .DEPTH (r + 1),
      .W     (bit_width)
    ) u_skew (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (act_hs ? act_data[r*bit_width +: bit_width] : '0),
      .in_valid  (act_hs),
      .out_data  (data_out[r*bit_width +: bit_width]),
      .out_valid (row_valid_out[r])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with ROWS=COLS=4, 8-bit elements.
module tb_systolic_feeder;
  import feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic        wt_valid = 1'b0;
  logic        wt_ready;
  logic [31:0] wt_data = '0;
  logic        act_valid = 1'b0;
  logic        act_ready;
  logic [31:0] act_data = '0;
  logic        ctrl_out;
  logic [31:0] wt_path_out;
  logic [31:0] data_out;
  logic [3:0]  row_valid_out;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  systolic_feeder #(
    .ROWS(4), .COLS(4), .bit_width(8), .CNT_W(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_vec       (num_vec),
    .wt_valid      (wt_valid),
    .wt_ready      (wt_ready),
    .wt_data       (wt_data),
    .act_valid     (act_valid),
    .act_ready     (act_ready),
    .act_data      (act_data),
    .ctrl_out      (ctrl_out),
    .wt_path_out   (wt_path_out),
    .data_out      (data_out),
    .row_valid_out (row_valid_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Weight beat b: column c holds seed + 16*b + c.
  function automatic logic [31:0] wbeat(input logic [7:0] seed, input int b);
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = seed + 8'(16*b + c);
    return v;
  endfunction

  // Activation vector idx: row r holds base + 16*idx + r.
  function automatic logic [31:0] avec(input logic [7:0] base, input int idx);
    logic [31:0] v;
    for (int r = 0; r < 4; r++) v[r*8 +: 8] = base + 8'(16*idx + r);
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"},  64'(ctrl_out), 64'd0);
    chk({tag, "_wpath"}, 64'(wt_path_out), 64'd0);
    chk({tag, "_data"},  64'(data_out), 64'd0);
    chk({tag, "_rvld"},  64'(row_valid_out), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_wrdy"},  64'(wt_ready), 64'd0);
    chk({tag, "_ardy"},  64'(act_ready), 64'd0);
  endtask

  task automatic begin_job(input logic [15:0] nv);
    chk("idle_busy", 64'(busy), 64'd0);
    start = 1'b1;
    num_vec = nv;
    tick();
    start = 1'b0;
    num_vec = 16'hdead;
    chk("start_busy", 64'(busy), 64'd1);
  endtask

  // Feeds 4 weight beats using valid pattern vpat (then all ones); optional start poke.
  task automatic load_weights(input logic [7:0] seed, input logic [15:0] vpat, input int npat,
                              input logic poke_start, input logic [15:0] poke_nv);
    int beats = 0;
    int cyc = 0;
    while (beats < 4 && cyc < 40) begin
      chk("wt_ready", 64'(wt_ready), 64'd1);
      chk("ld_act_ready", 64'(act_ready), 64'd0);
      wt_valid = (cyc < npat) ? vpat[cyc] : 1'b1;
      wt_data  = wbeat(seed, beats);
      if (poke_start && cyc == 0) begin
        start = 1'b1;
        num_vec = poke_nv;
      end
      tick();
      start = 1'b0;
      if (wt_valid) begin
        chk("ld_ctrl_hi", 64'(ctrl_out), 64'd1);
        chk("ld_wpath", 64'(wt_path_out), 64'(wbeat(seed, beats)));
        beats++;
      end else begin
        chk("ld_ctrl_lo", 64'(ctrl_out), 64'd0);
      end
      chk("ld_data_zero", 64'({data_out, row_valid_out}), 64'd0);
      chk("ld_done", 64'(done), 64'd0);
      cyc++;
    end
    wt_valid = 1'b0;
    if (beats < 4) chk("wt_timeout", 64'(beats), 64'd4);
  endtask

  // Streams nv vectors with valid pattern apat (then all ones) and checks through DONE/IDLE.
  task automatic stream(input int nv, input logic [15:0] apat, input int npat,
                        input logic [7:0] base, input logic [31:0] lastw);
    logic        hv [64];
    logic [31:0] hd [64];
    logic [31:0] exp_d;
    logic [3:0]  exp_v;
    logic        exp_ready;
    logic        hs;
    int left = nv;
    int idx = 0;
    int k = 0;
    int k_last = -1;
    bit finished = 1'b0;
    for (int i = 0; i < 64; i++) begin
      hv[i] = 1'b0;
      hd[i] = '0;
    end
    while (k < 60 && !finished) begin
      exp_ready = (left > 0);
      chk("act_ready", 64'(act_ready), 64'(exp_ready));
      act_valid = (k < npat) ? apat[k] : 1'b1;
      act_data  = avec(base, idx);
      tick();
      hs = act_valid && exp_ready;
      hv[k] = hs;
      hd[k] = act_data;
      if (hs) begin
        left--;
        idx++;
        if (left == 0) k_last = k;
      end
      exp_d = '0;
      exp_v = '0;
      for (int r = 0; r < 4; r++) begin
        if (k - r >= 0 && hv[k-r]) begin
          exp_d[r*8 +: 8] = hd[k-r][r*8 +: 8];
          exp_v[r] = 1'b1;
        end
      end
      chk("st_data", 64'(data_out), 64'(exp_d));
      chk("st_rvld", 64'(row_valid_out), 64'(exp_v));
      chk("st_ctrl", 64'(ctrl_out), 64'd0);
      chk("st_wpath", 64'(wt_path_out), 64'(lastw));
      if (left == 0) begin
        chk("st_done", 64'(done), 64'(k == k_last + 3));
        chk("st_busy", 64'(busy), 64'(k < k_last + 4));
        if (k == k_last + 4) finished = 1'b1;
      end else begin
        chk("st_done_lo", 64'(done), 64'd0);
        chk("st_busy_hi", 64'(busy), 64'd1);
      end
      k++;
    end
    act_valid = 1'b0;
    if (!finished) chk("job_timeout", 64'(k), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_rst");

    // Basic job: 3 vectors, back-to-back weights
    begin_job(16'd3);
    load_weights(8'h40, 16'hffff, 0, 1'b0, 16'd0);
    stream(3, 16'hffff, 0, 8'h10, wbeat(8'h40, 3));

    // Weight stall pattern 1,0,0,1,1,0,1
    begin_job(16'd1);
    load_weights(8'h80, 16'h0059, 7, 1'b0, 16'd0);
    stream(1, 16'hffff, 0, 8'h20, wbeat(8'h80, 3));

    // Activation bubble 1,0,1 with two vectors
    begin_job(16'd2);
    load_weights(8'h00, 16'hffff, 0, 1'b0, 16'd0);
    stream(2, 16'h0005, 3, 8'h30, wbeat(8'h00, 3));

    // Zero-vector job: weights load, FLUSH then DONE
    begin_job(16'd0);
    load_weights(8'hc0, 16'hffff, 0, 1'b0, 16'd0);
    stream(0, 16'hffff, 0, 8'h60, wbeat(8'hc0, 3));

    // Reset between edges after one accepted vector
    begin_job(16'd3);
    load_weights(8'h11, 16'hffff, 0, 1'b0, 16'd0);
    chk("mid_ardy", 64'(act_ready), 64'd1);
    act_valid = 1'b1;
    act_data  = avec(8'h50, 0);
    tick();
    act_valid = 1'b0;
    chk("mid_row0", 64'(row_valid_out), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    #2 rst_n = 1'b1;
    tick();
    chk_all_zero("after_mid_rst");
    begin_job(16'd2);
    load_weights(8'h22, 16'hffff, 0, 1'b0, 16'd0);
    stream(2, 16'hffff, 0, 8'h70, wbeat(8'h22, 3));

    // start during LOAD_WT with a different count is ignored
    begin_job(16'd2);
    load_weights(8'h33, 16'hffff, 0, 1'b1, 16'd5);
    stream(2, 16'hffff, 0, 8'h90, wbeat(8'h33, 3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
